// File: rtl/cla_bist_checker.sv
// Built-in self-test sweeper for a 4-bit carry-lookahead adder: walks all 512
// {cin,a,b} vectors, compares the adder against a golden sum, reports errors.
module cla_bist_checker #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic       op_cin,
  input  logic [3:0] dut_sum,
  input  logic       dut_cout,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [9:0] err_count,
  output logic [8:0] first_fail
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  localparam logic [3:0] SETTLE_L = 4'(SETTLE);

  state_t     state, state_nx;
  logic [8:0] vec;
  logic [3:0] settle_cnt;
  logic       accept;
  logic       mismatch;
  logic [9:0] err_nx;
  logic       busy_nx, done_nx, pass_nx;

  function automatic logic [4:0] golden(input logic [8:0] v);
    return {1'b0, v[7:4]} + {1'b0, v[3:0]} + {4'b0000, v[8]};
  endfunction

  // Operands come straight from the vector register, so they are registered
  // and naturally sit at 0 in IDLE and at the last vector in DONE.
  assign op_cin = vec[8];
  assign op_a   = vec[7:4];
  assign op_b   = vec[3:0];

  assign accept   = start && (state == IDLE || state == DONE);
  assign mismatch = (state == CHECK) && ({dut_cout, dut_sum} != golden(vec));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = DRIVE;
      DRIVE:   if (settle_cnt <= 4'd1) state_nx = CHECK;
      CHECK:   state_nx = (vec == 9'd511) ? DONE : DRIVE;
      DONE:    if (start) state_nx = DRIVE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    err_nx = err_count;
    if (accept)        err_nx = '0;
    else if (mismatch) err_nx = err_count + 10'd1;
    busy_nx = (state_nx == DRIVE) || (state_nx == CHECK);
    done_nx = (state_nx == DONE);
    pass_nx = done_nx && (err_nx == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec        <= '0;
      settle_cnt <= '0;
      err_count  <= '0;
      first_fail <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      busy      <= busy_nx;
      done      <= done_nx;
      pass      <= pass_nx;
      err_count <= err_nx;
      if (accept) begin
        vec        <= '0;
        first_fail <= '0;
        settle_cnt <= SETTLE_L;
      end else begin
        if (state == DRIVE)
          settle_cnt <= settle_cnt - 4'd1;
        if (state == CHECK && vec != 9'd511) begin
          vec        <= vec + 9'd1;
          settle_cnt <= SETTLE_L;
        end
        if (mismatch && err_count == '0)
          first_fail <= vec;
      end
    end
  end

endmodule

// File: tb/tb_cla_bist_checker.sv
// Bench for cla_bist_checker: behavioural adder with injectable faults, two
// instances (SETTLE=1 and SETTLE=3), operand and result scoreboards.
module tb_cla_bist_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start1 = 1'b0, start3 = 1'b0;
  int         mode = 0;
  logic       sel3 = 1'b0;

  logic [3:0] op_a1, op_b1, op_a3, op_b3, sum1, sum3;
  logic       op_cin1, op_cin3, cout1, cout3;
  logic       busy1, done1, pass1, busy3, done3, pass3;
  logic [9:0] err1, err3;
  logic [8:0] ff1, ff3;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    int         mode;
    logic       pass;
    logic [9:0] err;
    logic [8:0] ff;
  } rec_t;

  rec_t       tbl[3];
  rec_t       res_q[$];
  logic [8:0] op_q[$];

  always #5 clk = ~clk;

  function automatic logic [4:0] adder(input int m, input logic [3:0] a, input logic [3:0] b,
                                       input logic c);
    logic [4:0] r;
    r = {1'b0, a} + {1'b0, b} + {4'b0000, c};
    if (m == 1) r[4] = 1'b0;
    if (m == 2) r[0] = ~r[0];
    return r;
  endfunction

  assign {cout1, sum1} = adder(mode, op_a1, op_b1, op_cin1);
  assign {cout3, sum3} = adder(mode, op_a3, op_b3, op_cin3);

  cla_bist_checker #(.SETTLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op_a(op_a1), .op_b(op_b1), .op_cin(op_cin1),
    .dut_sum(sum1), .dut_cout(cout1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail(ff1));

  cla_bist_checker #(.SETTLE(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .op_a(op_a3), .op_b(op_b3), .op_cin(op_cin3),
    .dut_sum(sum3), .dut_cout(cout3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .first_fail(ff3));

  logic [8:0] m_op;
  logic       m_busy, m_done, m_pass;
  logic [9:0] m_err;
  logic [8:0] m_ff;
  assign m_op   = sel3 ? {op_cin3, op_a3, op_b3} : {op_cin1, op_a1, op_b1};
  assign m_busy = sel3 ? busy3 : busy1;
  assign m_done = sel3 ? done3 : done1;
  assign m_pass = sel3 ? pass3 : pass1;
  assign m_err  = sel3 ? err3 : err1;
  assign m_ff   = sel3 ? ff3 : ff1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    if (sel3) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  // One full sweep: operands checked at the first and last cycle of every
  // vector slot, final status checked against the queued expectation.
  task automatic run_sweep(input int s, input rec_t r);
    int   n;
    rec_t e;
    n = 512 * (s + 1);
    for (int v = 0; v < 512; v++) op_q.push_back(9'(v));
    res_q.push_back(r);
    mode = r.mode;
    pulse_start();
    check("accept_done_low", int'(m_done), 0);
    check("accept_err_clear", int'(m_err), 0);
    check("accept_ff_clear", int'(m_ff), 0);
    check("accept_busy", int'(m_busy), 1);
    for (int c = 0; c <= n; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      if (c < n && (c % (s + 1)) == 0) begin
        e.ff = op_q.pop_front();
        check("op_vec", int'(m_op), int'(e.ff));
      end
      if (c < n && (c % (s + 1)) == s)
        check("op_stable", int'(m_op), c / (s + 1));
      if (c == n - 1) check("done_early", int'(m_done), 0);
    end
    e = res_q.pop_front();
    check("done_rise", int'(m_done), 1);
    check("busy_end", int'(m_busy), 0);
    check("pass", int'(m_pass), int'(e.pass));
    check("err_count", int'(m_err), int'(e.err));
    check("first_fail", int'(m_ff), int'(e.ff));
    check("op_hold_done", int'(m_op), 511);
  endtask

  initial begin
    tbl[0] = '{mode: 1, pass: 1'b0, err: 10'd256, ff: 9'h01F};
    tbl[1] = '{mode: 2, pass: 1'b0, err: 10'd512, ff: 9'h000};
    tbl[2] = '{mode: 0, pass: 1'b1, err: 10'd0,   ff: 9'h000};

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy1), 0);
    check("rst_done", int'(done1), 0);
    check("rst_pass", int'(pass1), 0);
    check("rst_err", int'(err1), 0);
    check("rst_ff", int'(ff1), 0);
    check("rst_op", int'({op_cin1, op_a1, op_b1}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_op", int'({op_cin1, op_a1, op_b1}), 0);
    check("idle_busy", int'(busy1), 0);

    // Back-to-back sweeps: each start after the first is taken from DONE.
    sel3 = 1'b0;
    for (int i = 0; i < 3; i++) run_sweep(1, tbl[i]);
    repeat (3) @(posedge clk);
    #1;
    check("done_holds", int'(done1), 1);

    sel3 = 1'b1;
    run_sweep(3, tbl[2]);

    // Re-pulse start while busy, then reset at vec=100.
    sel3 = 1'b0;
    mode = 0;
    pulse_start();
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (c == 51) begin
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        c++;
      end
    end
    check("busy_repulse_vec", int'({op_cin1, op_a1, op_b1}), 100);
    check("busy_mid", int'(busy1), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_op", int'({op_cin1, op_a1, op_b1}), 0);
    check("async_rst_busy", int'(busy1), 0);
    check("async_rst_done", int'(done1), 0);
    check("async_rst_err", int'(err1), 0);
    check("async_rst_pass", int'(pass1), 0);
    check("async_rst_ff", int'(ff1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_idle_busy", int'(busy1), 0);
    check("post_rst_idle_done", int'(done1), 0);
    check("post_rst_idle_op", int'({op_cin1, op_a1, op_b1}), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
